// File: rtl/cnn_pkg.sv
// Shared constants, enums and arithmetic helpers for the CNN conv-layer sequencer.
package cnn_pkg;

    localparam int KSIZE  = 5;
    localparam int KSIZE2 = KSIZE * KSIZE;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        DMA_READ_WIN  = 2'd0,
        DMA_WRITE     = 2'd1,
        DMA_READ_FILT = 2'd2,
        DMA_READ_BIAS = 2'd3
    } dma_mode_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_LD_BIAS, ST_LD_FILT, ST_RD_WIN, ST_CONV,
        ST_NEXT_IM, ST_WRITE, ST_NEXT_POS, ST_DONE
    } seq_state_e;

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Clamp a signed accumulator into the 16-bit pixel range instead of wrapping.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > 32'sd32767)  return 16'h7FFF;
        if (v < -32'sd32768) return 16'h8000;
        return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// DMA, filter-buffer bias and conv-unit signals shared between the sequencer and its datapath.
interface conv_layer_sequencer_if;
    import cnn_pkg::*;

    logic              dma_start;
    logic              dma_finish;
    logic [ADDR_W-1:0] dma_addr;
    logic [15:0]       dma_offset;
    logic [1:0]        dma_mode;
    logic [DATA_W-1:0] dma_wdata;
    logic [7:0]        bias_index;
    logic [DATA_W-1:0] bias_in;
    logic              conv_start;
    logic              conv_finish;
    logic [DATA_W-1:0] conv_result;

    modport master (
        output dma_start, dma_addr, dma_offset, dma_mode, dma_wdata, bias_index, conv_start,
        input  dma_finish, bias_in, conv_finish, conv_result
    );

    modport slave (
        input  dma_start, dma_addr, dma_offset, dma_mode, dma_wdata, bias_index, conv_start,
        output dma_finish, bias_in, conv_finish, conv_result
    );

endinterface

// File: rtl/conv_addr_gen.sv
// Combinational filter, window and output address generation for the conv-layer loop counters.
module conv_addr_gen
    import cnn_pkg::*;
(
    input  logic [7:0]        om,
    input  logic [7:0]        im,
    input  logic [7:0]        oy,
    input  logic [7:0]        ox,
    input  logic [7:0]        in_maps,
    input  logic [7:0]        in_size,
    input  logic [7:0]        out_size,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [ADDR_W-1:0] filt_base,
    output logic [ADDR_W-1:0] filt_addr,
    output logic [ADDR_W-1:0] win_addr,
    output logic [ADDR_W-1:0] out_addr
);

    // Sums are formed at 32 bits and truncated; the layer layout is trusted to fit.
    assign filt_addr = ADDR_W'(32'(filt_base)
                     + (32'(om) * 32'(in_maps) + 32'(im)) * 32'(KSIZE2));

    assign win_addr  = ADDR_W'(32'(img_base)
                     + 32'(im) * 32'(in_size) * 32'(in_size)
                     + 32'(oy) * 32'(in_size) + 32'(ox));

    assign out_addr  = ADDR_W'(32'(out_base)
                     + 32'(om) * 32'(out_size) * 32'(out_size)
                     + 32'(oy) * 32'(out_size) + 32'(ox));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequences one conv layer: per output pixel, loads filters and windows, runs the conv unit,
// accumulates over input maps, adds bias, saturates and writes the result through the DMA.
module conv_layer_sequencer
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        cfg_in_maps,
    input  logic [7:0]        cfg_out_maps,
    input  logic [7:0]        cfg_in_size,
    input  logic [ADDR_W-1:0] cfg_img_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [ADDR_W-1:0] cfg_filt_base,
    input  logic [ADDR_W-1:0] cfg_bias_base,
    conv_layer_sequencer_if.master bus,
    output logic              busy,
    output logic              finish,
    output logic              cfg_err
);

    localparam logic [3:0] S_IDLE     = ST_IDLE;
    localparam logic [3:0] S_LD_BIAS  = ST_LD_BIAS;
    localparam logic [3:0] S_LD_FILT  = ST_LD_FILT;
    localparam logic [3:0] S_RD_WIN   = ST_RD_WIN;
    localparam logic [3:0] S_CONV     = ST_CONV;
    localparam logic [3:0] S_NEXT_IM  = ST_NEXT_IM;
    localparam logic [3:0] S_WRITE    = ST_WRITE;
    localparam logic [3:0] S_NEXT_POS = ST_NEXT_POS;
    localparam logic [3:0] S_DONE     = ST_DONE;

    logic [3:0]              state;
    logic [7:0]              in_maps, out_maps, in_size, out_size;
    logic [7:0]              om, im, oy, ox;
    logic [ADDR_W-1:0]       img_base, out_base, filt_base, bias_base;
    logic [ADDR_W-1:0]       filt_addr, win_addr, out_addr;
    logic signed [ACC_W-1:0] acc;
    logic                    dma_start, conv_start;
    logic [ADDR_W-1:0]       dma_addr;
    logic [15:0]             dma_offset;
    logic [1:0]              dma_mode;
    logic [DATA_W-1:0]       dma_wdata;
    logic                    cfg_bad;

    assign cfg_bad = (cfg_in_maps == 8'd0) || (cfg_out_maps == 8'd0)
                  || (cfg_in_size < 8'(KSIZE));

    conv_addr_gen u_addr_gen (
        .om        (om),
        .im        (im),
        .oy        (oy),
        .ox        (ox),
        .in_maps   (in_maps),
        .in_size   (in_size),
        .out_size  (out_size),
        .img_base  (img_base),
        .out_base  (out_base),
        .filt_base (filt_base),
        .filt_addr (filt_addr),
        .win_addr  (win_addr),
        .out_addr  (out_addr)
    );

    assign bus.dma_start  = dma_start;
    assign bus.dma_addr   = dma_addr;
    assign bus.dma_offset = dma_offset;
    assign bus.dma_mode   = dma_mode;
    assign bus.dma_wdata  = dma_wdata;
    assign bus.conv_start = conv_start;
    assign bus.bias_index = om;

    // Each request state spends its first cycle with start low (re-arm), then raises start
    // together with registered operands and holds it until the matching finish is sampled.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is the first branch of the clocked block, and every
        // register (counters, accumulator, outputs) is cleared so an abandoned layer leaves no residue.
        if (reset) begin
            state      <= S_IDLE;
            in_maps    <= '0;
            out_maps   <= '0;
            in_size    <= '0;
            out_size   <= '0;
            img_base   <= '0;
            out_base   <= '0;
            filt_base  <= '0;
            bias_base  <= '0;
            om         <= '0;
            im         <= '0;
            oy         <= '0;
            ox         <= '0;
            acc        <= '0;
            dma_start  <= 1'b0;
            dma_addr   <= '0;
            dma_offset <= '0;
            dma_mode   <= '0;
            dma_wdata  <= '0;
            conv_start <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !finish) begin
                        in_maps   <= cfg_in_maps;
                        out_maps  <= cfg_out_maps;
                        in_size   <= cfg_in_size;
                        out_size  <= cfg_in_size - 8'(KSIZE - 1);
                        img_base  <= cfg_img_base;
                        out_base  <= cfg_out_base;
                        filt_base <= cfg_filt_base;
                        bias_base <= cfg_bias_base;
                        om <= '0;
                        im <= '0;
                        oy <= '0;
                        ox <= '0;
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                            finish  <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_LD_BIAS;
                        end
                    end
                end
                S_LD_BIAS: begin
                    if (!dma_start) begin
                        dma_start  <= 1'b1;
                        dma_mode   <= DMA_READ_BIAS;
                        dma_addr   <= bias_base;
                        dma_offset <= 16'(out_maps);
                    end else if (bus.dma_finish) begin
                        dma_start <= 1'b0;
                        state     <= S_LD_FILT;
                    end
                end
                S_LD_FILT: begin
                    if (!dma_start) begin
                        dma_start  <= 1'b1;
                        dma_mode   <= DMA_READ_FILT;
                        dma_addr   <= filt_addr;
                        dma_offset <= '0;
                        if (im == 8'd0) acc <= sext(bus.bias_in);
                    end else if (bus.dma_finish) begin
                        dma_start <= 1'b0;
                        state     <= S_RD_WIN;
                    end
                end
                S_RD_WIN: begin
                    if (!dma_start) begin
                        dma_start  <= 1'b1;
                        dma_mode   <= DMA_READ_WIN;
                        dma_addr   <= win_addr;
                        dma_offset <= 16'(in_size);
                    end else if (bus.dma_finish) begin
                        dma_start <= 1'b0;
                        state     <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (!conv_start) begin
                        conv_start <= 1'b1;
                    end else if (bus.conv_finish) begin
                        conv_start <= 1'b0;
                        acc        <= acc + sext(bus.conv_result);
                        state      <= S_NEXT_IM;
                    end
                end
                S_NEXT_IM: begin
                    if (im < in_maps - 8'd1) begin
                        im    <= im + 8'd1;
                        state <= S_LD_FILT;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!dma_start) begin
                        dma_start  <= 1'b1;
                        dma_mode   <= DMA_WRITE;
                        dma_addr   <= out_addr;
                        dma_offset <= '0;
                        dma_wdata  <= sat16(acc);
                    end else if (bus.dma_finish) begin
                        dma_start <= 1'b0;
                        state     <= S_NEXT_POS;
                    end
                end
                S_NEXT_POS: begin
                    im    <= '0;
                    state <= S_LD_FILT;
                    if (ox == out_size - 8'd1) begin
                        ox <= '0;
                        if (oy == out_size - 8'd1) begin
                            oy <= '0;
                            if (om == out_maps - 8'd1) begin
                                busy   <= 1'b0;
                                finish <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                om <= om + 8'd1;
                            end
                        end else begin
                            oy <= oy + 8'd1;
                        end
                    end else begin
                        ox <= ox + 8'd1;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    if (!start) begin
                        finish  <= 1'b0;
                        cfg_err <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench: DMA/conv responders plus a loop-level reference model of the request stream.
module tb_conv_layer_sequencer;
    import cnn_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        cfg_in_maps = '0, cfg_out_maps = '0, cfg_in_size = '0;
    logic [ADDR_W-1:0] cfg_img_base = '0, cfg_out_base = '0, cfg_filt_base = '0, cfg_bias_base = '0;
    logic              busy, finish, cfg_err;

    conv_layer_sequencer_if bus();

    conv_layer_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_in_maps   (cfg_in_maps),
        .cfg_out_maps  (cfg_out_maps),
        .cfg_in_size   (cfg_in_size),
        .cfg_img_base  (cfg_img_base),
        .cfg_out_base  (cfg_out_base),
        .cfg_filt_base (cfg_filt_base),
        .cfg_bias_base (cfg_bias_base),
        .bus           (bus),
        .busy          (busy),
        .finish        (finish),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    logic [15:0] bias_mem [256];
    assign bus.bias_in = bias_mem[bus.bias_index];

    typedef struct {
        int mode;
        int addr;
        int offset;   // -1: not checked
        int data;
    } req_t;

    req_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          dma_delay = 0;
    int          conv_delay = 0;
    bit          conv_hash = 1'b0;
    int          conv_const = 0;
    logic [15:0] last_filt = '0;
    logic [15:0] last_win = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in conv unit: the dot product is a fixed function of which filter and window were loaded.
    function automatic int conv_val(input int f, input int w);
        if (!conv_hash) return conv_const;
        return ((f * 7 + w * 13) % 401) - 200;
    endfunction

    function automatic int pick(input int d);
        return (d < 0) ? int'($urandom_range(0, 3)) : d;
    endfunction

    task automatic dma_serve();
        req_t r;
        int   d;
        bit   aborted;
        aborted = 1'b0;
        if (exp_q.size() == 0) begin
            check("dma_unexpected", 32'(bus.dma_start), 32'd0);
        end else begin
            r = exp_q.pop_front();
            check("dma_mode", 32'(bus.dma_mode), r.mode);
            check("dma_addr", 32'(bus.dma_addr), r.addr);
            if (r.offset >= 0) check("dma_offset", 32'(bus.dma_offset), r.offset);
            if (r.mode == 1) check("dma_wdata", 32'(bus.dma_wdata), r.data & 32'hFFFF);
        end
        if (bus.dma_mode == 2'd2) last_filt = bus.dma_addr;
        if (bus.dma_mode == 2'd0) last_win = bus.dma_addr;
        d = pick(dma_delay);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (reset) begin aborted = 1'b1; break; end
        end
        if (!aborted) begin
            if (d > 0) check("dma_hold", 32'(bus.dma_start), 32'd1);
            bus.dma_finish = 1'b1;
            @(negedge clk);
            bus.dma_finish = 1'b0;
            if (!reset) check("dma_drop", 32'(bus.dma_start), 32'd0);
        end
    endtask

    task automatic conv_serve();
        int d;
        bit aborted;
        aborted = 1'b0;
        d = pick(conv_delay);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (reset) begin aborted = 1'b1; break; end
        end
        if (!aborted) begin
            bus.conv_result = 16'(conv_val(int'(last_filt), int'(last_win)));
            bus.conv_finish = 1'b1;
            @(negedge clk);
            bus.conv_finish = 1'b0;
            if (!reset) check("conv_drop", 32'(bus.conv_start), 32'd0);
        end
    endtask

    initial begin
        bus.dma_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.dma_start) dma_serve();
        end
    end

    initial begin
        bus.conv_finish = 1'b0;
        bus.conv_result = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.conv_start) conv_serve();
        end
    end

    // Reference: walk om, oy, ox, im and list every DMA request the layer must issue.
    task automatic build_expect(input int inm, input int outm, input int n);
        int m, acc, f, w, o;
        m = n - KSIZE + 1;
        exp_q.delete();
        exp_q.push_back('{3, int'(cfg_bias_base), outm, 0});
        for (int om = 0; om < outm; om++)
            for (int oy = 0; oy < m; oy++)
                for (int ox = 0; ox < m; ox++) begin
                    acc = int'($signed(bias_mem[om]));
                    for (int im = 0; im < inm; im++) begin
                        f = (int'(cfg_filt_base) + (om * inm + im) * KSIZE * KSIZE) & 32'hFFFF;
                        w = (int'(cfg_img_base) + im * n * n + oy * n + ox) & 32'hFFFF;
                        exp_q.push_back('{2, f, -1, 0});
                        exp_q.push_back('{0, w, n, 0});
                        acc += conv_val(f, w);
                    end
                    if (acc > 32767) acc = 32767;
                    if (acc < -32768) acc = -32768;
                    o = (int'(cfg_out_base) + om * m * m + oy * m + ox) & 32'hFFFF;
                    exp_q.push_back('{1, o, -1, acc});
                end
    endtask

    task automatic set_cfg(input int inm, input int outm, input int n);
        cfg_in_maps   = 8'(inm);
        cfg_out_maps  = 8'(outm);
        cfg_in_size   = 8'(n);
        cfg_img_base  = 16'($urandom_range(0, 65535));
        cfg_out_base  = 16'($urandom_range(0, 65535));
        cfg_filt_base = 16'($urandom_range(0, 65535));
        cfg_bias_base = 16'($urandom_range(0, 65535));
    endtask

    task automatic check_outputs_zero();
        check("rst_dma_start", 32'(bus.dma_start), 32'd0);
        check("rst_dma_addr", 32'(bus.dma_addr), 32'd0);
        check("rst_dma_offset", 32'(bus.dma_offset), 32'd0);
        check("rst_dma_mode", 32'(bus.dma_mode), 32'd0);
        check("rst_dma_wdata", 32'(bus.dma_wdata), 32'd0);
        check("rst_bias_index", 32'(bus.bias_index), 32'd0);
        check("rst_conv_start", 32'(bus.conv_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
    endtask

    task automatic run_layer(input int inm, input int outm, input int n, input int dd, input int cd);
        set_cfg(inm, outm, n);
        dma_delay  = dd;
        conv_delay = cd;
        build_expect(inm, outm, n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int c = 0; c < 30000 && !finish; c++) @(negedge clk);
        check("layer_finish", 32'(finish), 32'd1);
        check("layer_busy_low", 32'(busy), 32'd0);
        check("layer_cfg_err", 32'(cfg_err), 32'd0);
        check("layer_pending", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("finish_held", 32'(finish), 32'd1);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("finish_cleared", 32'(finish), 32'd0);
    endtask

    task automatic run_bad(input int inm, input int outm, input int n);
        set_cfg(inm, outm, n);
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 2 && !finish; c++) @(negedge clk);
        check("bad_finish", 32'(finish), 32'd1);
        check("bad_cfg_err", 32'(cfg_err), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("bad_held", 32'(finish & cfg_err), 32'd1);
        check("bad_no_dma", 32'(bus.dma_start), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("bad_clr_finish", 32'(finish), 32'd0);
        check("bad_clr_err", 32'(cfg_err), 32'd0);
    endtask

    task automatic run_reset_in_conv();
        set_cfg(1, 1, 5);
        conv_hash  = 1'b1;
        dma_delay  = 0;
        conv_delay = 40;
        build_expect(1, 1, 5);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 500 && !bus.conv_start; c++) @(negedge clk);
        check("conv_reached", 32'(bus.conv_start), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_outputs_zero();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_layer(2, 1, 5, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bias_mem[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        check_outputs_zero();
        reset = 1'b0;
        @(negedge clk);

        // All-ones window and filter: 25 per window, plus bias 2.
        conv_hash = 1'b0;
        conv_const = 25;
        bias_mem[0] = 16'd2;
        run_layer(1, 1, 5, 0, 0);

        conv_const = 100;
        bias_mem[0] = 16'($urandom_range(0, 50));
        run_layer(2, 1, 6, 1, 1);

        bias_mem[0] = 16'($urandom_range(0, 50));
        conv_const = 30000;
        run_layer(3, 1, 5, 7, 2);
        conv_const = -30000;
        run_layer(3, 1, 5, 7, 0);

        conv_hash = 1'b1;
        for (int i = 0; i < 256; i++) bias_mem[i] = 16'($urandom);
        for (int t = 0; t < 5; t++)
            run_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 2)),
                      int'($urandom_range(5, 7)), -1, -1);

        run_reset_in_conv();

        run_bad(1, 1, 4);
        run_bad(0, 2, 6);
        run_bad(2, 0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
